// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Serial line, per-frame configuration and received-byte
//                reporting bundle shared by the UART receiver and its user.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_if;
  logic       rx;           // asynchronous serial line, idle high
  logic [1:0] baud_rate;    // tick divider select
  logic [1:0] parity_type;  // 00 none, 01 even, 10 odd, 11 none
  logic       stop_bits;    // 0 = one stop bit, 1 = two stop bits
  logic [7:0] data_out;     // received byte
  logic       data_valid;   // one-clock strobe for data_out and flags
  logic       parity_err;   // parity mismatch in last frame
  logic       frame_err;    // a stop bit sampled low in last frame
  logic       rx_active;    // a frame is being received

  // User side: drives the line and configuration, observes the results
  modport master (
    output rx, baud_rate, parity_type, stop_bits,
    input  data_out, data_valid, parity_err, frame_err, rx_active
  );

  // Receiver side
  modport slave (
    input  rx, baud_rate, parity_type, stop_bits,
    output data_out, data_valid, parity_err, frame_err, rx_active
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver with 16x oversampling. Frame: start bit,
//                8 data bits LSB first, optional even/odd parity, 1 or 2
//                stop bits. Delivers each byte with a one-clock strobe and
//                parity / framing error flags.
//                Optional build macro UART_RX_MAJORITY_EN: each bit is the
//                2-of-3 majority of the samples at ticks 6, 7 and 8, decided
//                at tick 8. Without it a single sample at tick 7 is used.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int TICK_DIV0 = 1302,  // clocks per 16x tick, baud_rate = 00
  parameter int TICK_DIV1 = 651,   // baud_rate = 01
  parameter int TICK_DIV2 = 326,   // baud_rate = 10
  parameter int TICK_DIV3 = 163    // baud_rate = 11
) (
  input  logic     clock,
  input  logic     rst,
  uart_rx_if.slave bus
);

  // --------------------------------------------------------------------------
  // Divider sizing: wide enough for the largest terminal count
  // --------------------------------------------------------------------------
  localparam int c_div_max01 = (TICK_DIV0 > TICK_DIV1) ? TICK_DIV0 : TICK_DIV1;
  localparam int c_div_max23 = (TICK_DIV2 > TICK_DIV3) ? TICK_DIV2 : TICK_DIV3;
  localparam int c_div_max   = (c_div_max01 > c_div_max23) ? c_div_max01 : c_div_max23;
  localparam int c_div_w     = $clog2(c_div_max + 1);

  localparam logic [c_div_w-1:0] c_term0 = c_div_w'(TICK_DIV0 - 1);
  localparam logic [c_div_w-1:0] c_term1 = c_div_w'(TICK_DIV1 - 1);
  localparam logic [c_div_w-1:0] c_term2 = c_div_w'(TICK_DIV2 - 1);
  localparam logic [c_div_w-1:0] c_term3 = c_div_w'(TICK_DIV3 - 1);

  localparam logic [1:0] c_par_even = 2'b01;
  localparam logic [1:0] c_par_odd  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP1     = 3'd4,
    S_STOP2     = 3'd5,
    S_WAIT_IDLE = 3'd6
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_next;

  logic               r_rx_meta;     // first synchronizer stage
  logic               r_rx_s;        // synchronized line
  logic               r_rx_prev;     // previous synchronized value, edge detect

  logic [1:0]         r_cfg_baud;    // configuration latched per frame
  logic [1:0]         r_cfg_parity;
  logic               r_cfg_stop2;

  logic [c_div_w-1:0] r_div_cnt;
  logic [c_div_w-1:0] w_div_term;
  logic [3:0]         r_tick_cnt;
  logic               w_frame_run;
  logic               w_tick;
  logic               w_decide;
  logic               w_bit;

  logic [7:0]         r_shift;
  logic [2:0]         r_bit_idx;
  logic               r_perr;
  logic               r_ferr;
  logic               w_par_en;
  logic               w_par_exp;

  logic               w_fall;
  logic               w_start_det;
  logic               w_finish;

  logic [7:0]         r_data_out;
  logic               r_data_valid;
  logic               r_parity_err;
  logic               r_frame_err;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer plus a delayed copy for falling-edge detection;
  // all stages reset to the idle-high line level.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_fall      = r_rx_prev & ~r_rx_s;
  assign w_start_det = (r_state == S_IDLE) & w_fall;

  // Frame is in progress in every state between start detection and finish
  assign w_frame_run = (r_state == S_START)  || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP1) ||
                       (r_state == S_STOP2);

  // Select the divider terminal count from the configuration latched at start
  always_comb begin
    w_div_term = c_term3;
    case (r_cfg_baud)
      2'b00:   w_div_term = c_term0;
      2'b01:   w_div_term = c_term1;
      2'b10:   w_div_term = c_term2;
      default: w_div_term = c_term3;
    endcase
  end

  assign w_tick = w_frame_run && (r_div_cnt == w_div_term);

  // Clock divider: held at zero outside a frame so the first tick lands a
  // full divider period after start detection
  always_ff @(posedge clock) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (!w_frame_run || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // 16x tick counter: position within the current bit, wraps 15 -> 0
  always_ff @(posedge clock) begin
    if (rst) begin
      r_tick_cnt <= 4'd0;
    end else if (!w_frame_run) begin
      r_tick_cnt <= 4'd0;
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt + 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Bit decision point and bit value
  // --------------------------------------------------------------------------
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] c_decide_cnt = 4'd8;

  logic r_maj_a;  // sample at tick 6
  logic r_maj_b;  // sample at tick 7

  // Capture the two early samples; the third is the live line at tick 8
  always_ff @(posedge clock) begin
    if (rst) begin
      r_maj_a <= 1'b1;
      r_maj_b <= 1'b1;
    end else if (w_tick && (r_tick_cnt == 4'd6)) begin
      r_maj_a <= r_rx_s;
    end else if (w_tick && (r_tick_cnt == 4'd7)) begin
      r_maj_b <= r_rx_s;
    end
  end

  assign w_bit = (r_maj_a & r_maj_b) | (r_maj_a & r_rx_s) | (r_maj_b & r_rx_s);
`else
  localparam logic [3:0] c_decide_cnt = 4'd7;

  assign w_bit = r_rx_s;
`endif

  assign w_decide = w_tick && (r_tick_cnt == c_decide_cnt);

  // Parity expectation from the received data bits
  assign w_par_en  = (r_cfg_parity == c_par_even) || (r_cfg_parity == c_par_odd);
  assign w_par_exp = (^r_shift) ^ (r_cfg_parity == c_par_odd);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; w_finish marks the clock whose edge delivers the byte
  always_comb begin
    w_state_next = r_state;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_decide) begin
          w_state_next = w_bit ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_decide && (r_bit_idx == 3'd7)) begin
          w_state_next = w_par_en ? S_PARITY : S_STOP1;
        end
      end
      S_PARITY: begin
        if (w_decide) begin
          w_state_next = S_STOP1;
        end
      end
      S_STOP1: begin
        if (w_decide) begin
          if (r_cfg_stop2) begin
            w_state_next = S_STOP2;
          end else begin
            w_finish     = 1'b1;
            w_state_next = (r_ferr || !w_bit) ? S_WAIT_IDLE : S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (w_decide) begin
          w_finish     = 1'b1;
          w_state_next = (r_ferr || !w_bit) ? S_WAIT_IDLE : S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        // A held-low line (break) must return high before a new start
        if (r_rx_s) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Per-frame datapath: configuration latch, data shift, error accumulation
  always_ff @(posedge clock) begin
    if (rst) begin
      r_cfg_baud   <= 2'b00;
      r_cfg_parity <= 2'b00;
      r_cfg_stop2  <= 1'b0;
      r_shift      <= 8'h00;
      r_bit_idx    <= 3'd0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
    end else if (w_start_det) begin
      r_cfg_baud   <= bus.baud_rate;
      r_cfg_parity <= bus.parity_type;
      r_cfg_stop2  <= bus.stop_bits;
      r_bit_idx    <= 3'd0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
    end else if (w_decide) begin
      case (r_state)
        S_DATA: begin
          r_shift[r_bit_idx] <= w_bit;
          r_bit_idx          <= r_bit_idx + 3'd1;
        end
        S_PARITY: begin
          r_perr <= (w_bit != w_par_exp);
        end
        S_STOP1, S_STOP2: begin
          if (!w_bit) begin
            r_ferr <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers: updated together with the one-clock valid strobe
  always_ff @(posedge clock) begin
    if (rst) begin
      r_data_out   <= 8'h00;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= w_finish;
      if (w_finish) begin
        r_data_out   <= r_shift;
        r_parity_err <= r_perr;
        r_frame_err  <= r_ferr | ~w_bit;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.rx_active  = w_frame_run;

endmodule
`default_nettype wire
